spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per SPI word (MSB first).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning flop depth of the input synchronizers (minimum 2).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  system clock; all logic on posedge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: sclk  input  1  SPI clock from the master; idle low (mode 0).
REQ-007 Port: cs_n  input  1  active-low chip select for this slave.
REQ-008 Port: mosi  input  1  serial data from the master.
REQ-009 Port: miso  output  1  serial data to the master.
REQ-010 Port: miso_oe  output  1  MISO drive enable; high only while selected.
REQ-011 Port: tx_data  input  DATA_W  next word to transmit.
REQ-012 Port: tx_valid  input  1  tx_data is valid.
REQ-013 Port: tx_ready  output  1  TX holding buffer is empty.
REQ-014 Port: rx_data  output  DATA_W  last complete received word.
REQ-015 Port: rx_valid  output  1  rx_data holds an unconsumed word.
REQ-016 Port: rx_ready  input  1  consumer accepts rx_data.
REQ-017 Port: busy  output  1  frame in progress (cs_n low, synchronized).
REQ-018 Port: err  output  3  one-cycle pulses {frame_err, overrun, underrun}.

Function
REQ-019 sclk, cs_n and mosi SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized sclk; clk SHALL be at least 4x the sclk frequency.
REQ-020 FSM states SHALL be IDLE, LOAD, SHIFT; IDLE->LOAD on synchronized cs_n falling; LOAD->SHIFT after one cycle; any state->IDLE on synchronized cs_n high.
REQ-021 LOAD SHALL copy the TX buffer into the shift register if full (buffer becomes empty), else load all-zeros and pulse underrun; miso SHALL present shift[DATA_W-1] by the end of LOAD.
REQ-022 In SHIFT, each sclk rising edge SHALL shift mosi into the RX register MSB first and increment bit_cnt.
REQ-023 In SHIFT, each sclk falling edge SHALL shift the TX register left, driving the next bit on miso.
REQ-024 On the DATA_W-th rising edge, the RX word SHALL be written to rx_data with rx_valid=1 on the next clk, and bit_cnt SHALL wrap to 0.
REQ-025 If cs_n remains low after a word, the falling sclk edge following the DATA_W-th rising edge SHALL reload from the TX buffer per REQ-021 (back-to-back words).
REQ-026 The TX buffer is one entry: tx_ready=!full; tx_valid&&tx_ready loads it; a load and a consume in the same cycle SHALL leave it full with the new data.
REQ-027 rx_valid SHALL stay high until rx_valid&&rx_ready; a word completing while rx_valid is high SHALL overwrite rx_data and pulse overrun; completion and acceptance in the same cycle SHALL leave rx_valid=1 without overrun.
REQ-028 cs_n rising with bit_cnt!=0 SHALL discard the partial word, pulse frame_err and leave rx_data/rx_valid unchanged; with bit_cnt==0 it SHALL produce no error.
REQ-029 miso_oe SHALL equal busy; miso SHALL be 0 when miso_oe=0.
REQ-030 sclk edges while cs_n is high SHALL be ignored.

Reset
REQ-031 On rst_n low: state=IDLE, miso=0, miso_oe=0, busy=0, tx_ready=1 (buffer empty), rx_data=0, rx_valid=0, err=0, bit_cnt=0, synchronizers preset to idle (sclk=0, cs_n=1, mosi=0).
REQ-032 Reset mid-frame SHALL abort immediately with no error pulse; after release the block SHALL wait for a fresh cs_n falling edge.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enum, DATA_W default, and the err bit-index constants (ERR_FRAME=2, ERR_OVERRUN=1, ERR_UNDERRUN=0).
REQ-034 One sub-module spi_sync (SYNC_STAGES-deep flop chain with reset value parameter) SHALL be instantiated per input.

Verification
REQ-035 Load tx 0xA5, master sends 0x3C -> master receives 0xA5; rx_data=0x3C, rx_valid=1 until rx_ready.
REQ-036 Two back-to-back words, tx 0x11 then 0x22, master sends 0x81, 0x42 -> miso 0x11,0x22; rx words 0x81,0x42; no err.
REQ-037 Empty TX buffer at frame start, master sends 0xFF -> miso 0x00, underrun pulse once, rx_data=0xFF.
REQ-038 Hold rx_ready=0 over two words 0x01,0x02 -> overrun pulse on second, rx_data=0x02.
REQ-039 cs_n deasserted after 5 bits -> frame_err pulse, rx_valid unchanged, miso_oe=0, state IDLE.
REQ-040 rst_n asserted after 3 bits -> all outputs at REQ-031 values, no err pulse; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM states, default word width and
// bit positions inside the err pulse vector.
package spi_pkg;

    localparam int unsigned DATA_W_DEF   = 8;

    localparam int unsigned ERR_FRAME    = 2;
    localparam int unsigned ERR_OVERRUN  = 1;
    localparam int unsigned ERR_UNDERRUN = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input; reset drives the chain
// to the input's idle level so no spurious edge appears after reset.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave with a one-entry TX holding buffer, RX output register with
// valid/ready handshake, and one-cycle error pulses {frame, overrun, underrun}.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic [2:0]        err
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic w_sclk, w_cs_n, w_mosi;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(w_sclk));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n), .q(w_cs_n));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi), .q(w_mosi));

    spi_state_t        r_state, w_state_next;
    logic              r_sclk_d, r_cs_d;
    logic [DATA_W-1:0] r_tx_buf, r_tx_shift, r_rx_data;
    logic [DATA_W-2:0] r_rx_shift;
    logic              r_tx_full, r_rx_valid, r_udr_pend;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [2:0]        r_err, w_err_next;

    logic              w_cs_fall, w_shifting, w_rise, w_fall, w_reload;
    logic              w_load, w_last_bit, w_tx_take;
    logic [DATA_W-1:0] w_rx_word;

    assign w_cs_fall  = r_cs_d & ~w_cs_n;
    assign w_shifting = (r_state == SHIFT) & ~w_cs_n;
    assign w_rise     = w_shifting & w_sclk & ~r_sclk_d;
    assign w_fall     = w_shifting & ~w_sclk & r_sclk_d;
    assign w_reload   = w_fall & (r_bit_cnt == '0);
    assign w_load     = ((r_state == LOAD) & ~w_cs_n) | w_reload;
    assign w_last_bit = w_rise & (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_rx_word  = {r_rx_shift, w_mosi};
    assign w_tx_take  = tx_valid & ~r_tx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_next = LOAD;
            LOAD:    w_state_next = w_cs_n ? IDLE : SHIFT;
            SHIFT:   if (w_cs_n) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != IDLE);
        miso_oe = busy;
        miso    = busy & r_tx_shift[DATA_W-1];
    end

    // A reload after the last falling edge of a word also happens at frame end;
    // its underrun is held pending and only reported once that word really starts.
    always_comb begin
        w_err_next               = '0;
        w_err_next[ERR_FRAME]    = (r_state == SHIFT) & w_cs_n & (r_bit_cnt != '0);
        w_err_next[ERR_OVERRUN]  = w_last_bit & r_rx_valid & ~rx_ready;
        w_err_next[ERR_UNDERRUN] = ((r_state == LOAD) & ~w_cs_n & ~r_tx_full)
                                 | (w_rise & r_udr_pend);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d   <= 1'b0;
            r_cs_d     <= 1'b1;
            r_tx_buf   <= '0;
            r_tx_full  <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_bit_cnt  <= '0;
            r_udr_pend <= 1'b0;
            r_err      <= '0;
        end else begin
            r_sclk_d <= w_sclk;
            r_cs_d   <= w_cs_n;
            r_err    <= w_err_next;

            if (w_tx_take) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end else if (w_load) begin
                r_tx_full <= 1'b0;
            end

            if (w_load) begin
                r_tx_shift <= r_tx_full ? r_tx_buf : '0;
            end else if (w_fall) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            end

            if (!w_shifting) begin
                r_udr_pend <= 1'b0;
            end else if (w_reload) begin
                r_udr_pend <= ~r_tx_full;
            end else if (w_rise) begin
                r_udr_pend <= 1'b0;
            end

            if (!w_shifting) begin
                r_bit_cnt <= '0;
            end else if (w_rise) begin
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
            end

            if (w_rise) begin
                r_rx_shift <= w_rx_word[DATA_W-2:0];
            end

            if (w_last_bit) begin
                r_rx_data  <= w_rx_word;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid & rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign tx_ready = ~r_tx_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign err      = r_err;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged mode-0 master plus a word-level
// model (a word sent with the TX buffer empty reads back as zero and counts one underrun).
module tb_spi_slave;

    localparam int HP = 8;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0, rx_ready = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy;
    logic [7:0] rx_data;
    logic [2:0] err;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .busy(busy), .err(err));

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0;
    int n_frame = 0, n_over = 0, n_under = 0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (err[2]) n_frame++;
        if (err[1]) n_over++;
        if (err[0]) n_under++;
        if (rx_valid && rx_ready) rx_log.push_back(rx_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_tx(input logic [7:0] w);
        int t = 0;
        while (!tx_ready && t < 200) begin tick(1); t++; end
        n_chk++;
        if (tx_ready !== 1'b1) $display("FAIL push_tx_timeout: tx_ready=%b want 1", tx_ready);
        else n_pass++;
        tx_data = w; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic consume();
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    endtask

    task automatic start_frame();
        cs_n = 1'b0; tick(8);
    endtask

    task automatic end_frame();
        tick(HP); cs_n = 1'b1; mosi = 1'b0; tick(8);
    endtask

    task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            tick(HP);
            sclk = 1'b1;
            got[7-i] = miso;
            tick(HP);
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        tick(3);
        @(negedge clk);
        n_chk++;
        if ({miso, miso_oe, busy, tx_ready, rx_valid} !== 5'b00010)
            $display("FAIL reset_ctrl: {miso,oe,busy,tx_ready,rx_valid}=%b want 00010",
                     {miso, miso_oe, busy, tx_ready, rx_valid});
        else n_pass++;
        n_chk++;
        if ({rx_data, err} !== 11'h0) $display("FAIL reset_data: rx_data=%h err=%b want 00/000", rx_data, err);
        else n_pass++;
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_basic();
        logic [7:0] got;
        int f0 = n_frame, o0 = n_over, u0 = n_under;
        push_tx(8'hA5);
        n_chk++;
        if (tx_ready !== 1'b0) $display("FAIL basic_tx_full: tx_ready=%b want 0", tx_ready);
        else n_pass++;
        start_frame();
        n_chk++;
        if ({busy, miso_oe, miso, tx_ready} !== 4'b1111)
            $display("FAIL basic_load: {busy,oe,miso,tx_ready}=%b want 1111", {busy, miso_oe, miso, tx_ready});
        else n_pass++;
        xfer(8'h3C, 8, got);
        end_frame();
        n_chk++;
        if (got !== 8'hA5) $display("FAIL basic_miso: got %h want a5", got);
        else n_pass++;
        n_chk++;
        if ({rx_valid, rx_data} !== 9'h13C) $display("FAIL basic_rx: valid=%b data=%h want 1/3c", rx_valid, rx_data);
        else n_pass++;
        tick(20);
        n_chk++;
        if (rx_valid !== 1'b1) $display("FAIL basic_rx_hold: rx_valid=%b want 1", rx_valid);
        else n_pass++;
        consume();
        n_chk++;
        if (rx_valid !== 1'b0) $display("FAIL basic_rx_consume: rx_valid=%b want 0", rx_valid);
        else n_pass++;
        n_chk++;
        if ({n_frame - f0, n_over - o0, n_under - u0} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL basic_err: frame=%0d over=%0d under=%0d want 0/0/0", n_frame - f0, n_over - o0, n_under - u0);
        else n_pass++;
    endtask

    task automatic test_random_words();
        logic [7:0] got, tw, mw;
        bit have;
        int u0;
        for (int k = 0; k < 8; k++) begin
            tw = 8'($urandom); mw = 8'($urandom); have = 1'($urandom);
            u0 = n_under;
            if (have) push_tx(tw);
            start_frame();
            xfer(mw, 8, got);
            end_frame();
            n_chk++;
            if (got !== (have ? tw : 8'h00)) $display("FAIL rand_miso[%0d]: got %h want %h", k, got, have ? tw : 8'h00);
            else n_pass++;
            n_chk++;
            if (rx_data !== mw || n_under - u0 != (have ? 0 : 1))
                $display("FAIL rand_rx[%0d]: data=%h under=%0d want %h/%0d", k, rx_data, n_under - u0, mw, have ? 0 : 1);
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] m1, input logic [7:0] m2);
        logic [7:0] g1, g2;
        int f0 = n_frame, o0 = n_over, u0 = n_under;
        rx_log.delete();
        push_tx(a);
        rx_ready = 1'b1;
        start_frame();
        push_tx(b);
        xfer(m1, 8, g1);
        xfer(m2, 8, g2);
        end_frame();
        rx_ready = 1'b0;
        n_chk++;
        if ({g1, g2} !== {a, b}) $display("FAIL b2b_miso: got %h,%h want %h,%h", g1, g2, a, b);
        else n_pass++;
        n_chk++;
        if (rx_log.size() != 2) $display("FAIL b2b_rx_count: got %0d want 2", rx_log.size());
        else if ({rx_log[0], rx_log[1]} !== {m1, m2})
            $display("FAIL b2b_rx: got %h,%h want %h,%h", rx_log[0], rx_log[1], m1, m2);
        else n_pass++;
        n_chk++;
        if ({n_frame - f0, n_over - o0, n_under - u0} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL b2b_err: frame=%0d over=%0d under=%0d want 0/0/0", n_frame - f0, n_over - o0, n_under - u0);
        else n_pass++;
    endtask

    task automatic test_underrun();
        logic [7:0] got;
        int u0 = n_under;
        start_frame();
        xfer(8'hFF, 8, got);
        end_frame();
        n_chk++;
        if (got !== 8'h00) $display("FAIL underrun_miso: got %h want 00", got);
        else n_pass++;
        n_chk++;
        if (n_under - u0 != 1) $display("FAIL underrun_count: got %0d want 1", n_under - u0);
        else n_pass++;
        n_chk++;
        if (rx_data !== 8'hFF) $display("FAIL underrun_rx: got %h want ff", rx_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_overrun();
        logic [7:0] got;
        int o0 = n_over, u0 = n_under;
        start_frame();
        xfer(8'h01, 8, got);
        xfer(8'h02, 8, got);
        end_frame();
        n_chk++;
        if (n_over - o0 != 1) $display("FAIL overrun_count: got %0d want 1", n_over - o0);
        else n_pass++;
        n_chk++;
        if ({rx_valid, rx_data} !== 9'h102) $display("FAIL overrun_rx: valid=%b data=%h want 1/02", rx_valid, rx_data);
        else n_pass++;
        n_chk++;
        if (n_under - u0 != 2) $display("FAIL overrun_underruns: got %0d want 2", n_under - u0);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        logic [7:0] got;
        int f0 = n_frame;
        start_frame();
        xfer(8'($urandom), 5, got);
        tick(HP);
        cs_n = 1'b1;
        tick(8);
        n_chk++;
        if (n_frame - f0 != 1) $display("FAIL frame_err_count: got %0d want 1", n_frame - f0);
        else n_pass++;
        n_chk++;
        if ({rx_valid, rx_data} !== 9'h102) $display("FAIL frame_err_rx: valid=%b data=%h want 1/02", rx_valid, rx_data);
        else n_pass++;
        n_chk++;
        if ({miso_oe, busy, miso} !== 3'b000) $display("FAIL frame_err_idle: {oe,busy,miso}=%b want 000", {miso_oe, busy, miso});
        else n_pass++;
        consume();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got, tw;
        int f0 = n_frame, o0 = n_over, u0 = n_under;
        push_tx(8'($urandom));
        start_frame();
        push_tx(8'($urandom));
        xfer(8'($urandom), 3, got);
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({miso, miso_oe, busy, tx_ready, rx_valid} !== 5'b00010)
            $display("FAIL midrst_ctrl: {miso,oe,busy,tx_ready,rx_valid}=%b want 00010",
                     {miso, miso_oe, busy, tx_ready, rx_valid});
        else n_pass++;
        n_chk++;
        if ({rx_data, err} !== 11'h0) $display("FAIL midrst_data: rx_data=%h err=%b want 00/000", rx_data, err);
        else n_pass++;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        n_chk++;
        if ({n_frame - f0, n_over - o0, n_under - u0} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL midrst_err: frame=%0d over=%0d under=%0d want 0/0/0", n_frame - f0, n_over - o0, n_under - u0);
        else n_pass++;
        tw = 8'($urandom);
        push_tx(tw);
        start_frame();
        xfer(8'h5A, 8, got);
        end_frame();
        n_chk++;
        if (got !== tw) $display("FAIL midrst_miso: got %h want %h", got, tw);
        else n_pass++;
        n_chk++;
        if ({rx_valid, rx_data} !== 9'h15A) $display("FAIL midrst_rx: valid=%b data=%h want 1/5a", rx_valid, rx_data);
        else n_pass++;
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_words();
        test_back_to_back(8'h11, 8'h22, 8'h81, 8'h42);
        test_back_to_back(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        test_underrun();
        test_overrun();
        test_frame_err();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
